// File: rtl/clk_freq_meter_pkg.sv
// Shared state type and sizing helpers for the clock frequency meter.
package clk_freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2
   } meter_state_e;

   // Smallest width (at least 1) whose range covers 0 .. n-1.
   function automatic int unsigned gate_w(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

   function automatic int unsigned sat_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control/result bundle of the clock frequency meter; the meter is the slave side.
// FREQ_METER_PERIOD_EN adds the period result signals.
interface clk_freq_meter_if #(
   parameter int unsigned CNT_W = 16
);
   logic             ena;
   logic             sig_in;
   logic [CNT_W-1:0] count_o;
   logic             valid_o;
   logic             ovf_o;
   logic             busy_o;
`ifdef FREQ_METER_PERIOD_EN
   logic [CNT_W-1:0] period_o;
   logic             period_valid_o;

   modport master (
      output ena, sig_in,
      input  count_o, valid_o, ovf_o, busy_o, period_o, period_valid_o
   );
   modport slave (
      input  ena, sig_in,
      output count_o, valid_o, ovf_o, busy_o, period_o, period_valid_o
   );
`else
   modport master (
      output ena, sig_in,
      input  count_o, valid_o, ovf_o, busy_o
   );
   modport slave (
      input  ena, sig_in,
      output count_o, valid_o, ovf_o, busy_o
   );
`endif
endinterface

// File: rtl/clk_freq_meter_sync_rise_det.sv
// Multi-flop synchronizer plus rising-edge detector for an asynchronous input.
// prev tracks the synced level only while tracking or on an explicit load.
module sync_rise_det #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   input  logic track_i,
   input  logic load_prev_i,
   output logic rise_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   assign level = sync_q[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         if (track_i || load_prev_i) prev_q <= level;
      end
   end

   assign rise_o = level & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous clock over a fixed window of clk cycles.
// Defining FREQ_METER_PERIOD_EN adds a clk-cycle period measurement between edges.
//
// state   | meaning
// ST_IDLE | disabled, counters held at zero
// ST_ARM  | one cycle: snapshot synced level into prev, clear counters
// ST_GATE | window running; windows repeat back to back while ena is high
module clk_freq_meter
   import clk_freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 1000,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst_n,
   clk_freq_meter_if.slave mtr
);
   localparam int unsigned       GATE_W    = gate_w(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(sat_max(CNT_W));

   meter_state_e      state_q, state_d;
   logic              in_arm, in_gate;
   logic              rise, rise_g, win_end, run;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_next;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d, ovf_next;
   logic              ovf_out_q, ovf_out_d;
   logic              valid_q, valid_d;

   sync_rise_det #(.STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .async_i     (mtr.sig_in),
      .track_i     (in_gate),
      .load_prev_i (in_arm),
      .rise_o      (rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (mtr.ena) state_d = ST_ARM;
         ST_ARM:  state_d = mtr.ena ? ST_GATE : ST_IDLE;
         ST_GATE: if (!mtr.ena) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_arm  = 1'b0;
      in_gate = 1'b0;
      unique case (state_q)
         ST_ARM:  in_arm  = 1'b1;
         ST_GATE: in_gate = 1'b1;
         default: ;
      endcase
   end

   // A window that loses ena before its last cycle is discarded.
   assign run       = in_gate & mtr.ena;
   assign rise_g    = rise & in_gate;
   assign win_end   = run & (gate_cnt_q == GATE_LAST);
   assign edge_next = edge_cnt_q + CNT_W'(rise_g & (edge_cnt_q != CNT_MAX));
   assign ovf_next  = ovf_q | (edge_next == CNT_MAX);

   always_comb begin
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      ovf_d      = 1'b0;
      count_d    = count_q;
      ovf_out_d  = ovf_out_q;
      valid_d    = 1'b0;
      if (win_end) begin
         count_d   = edge_next;
         ovf_out_d = ovf_next;
         valid_d   = 1'b1;
      end else if (run) begin
         gate_cnt_d = gate_cnt_q + GATE_W'(1);
         edge_cnt_d = edge_next;
         ovf_d      = ovf_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         ovf_out_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         ovf_out_q  <= ovf_out_d;
         valid_q    <= valid_d;
      end
   end

   assign mtr.count_o = count_q;
   assign mtr.valid_o = valid_q;
   assign mtr.ovf_o   = ovf_out_q;
   assign mtr.busy_o  = in_gate;

`ifdef FREQ_METER_PERIOD_EN
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             seen_q, seen_d;
   logic             pvalid_q, pvalid_d;

   // The first rise of each window only starts the count; later rises report it.
   always_comb begin
      per_cnt_d = '0;
      seen_d    = 1'b0;
      period_d  = period_q;
      pvalid_d  = 1'b0;
      if (run) begin
         per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
         seen_d    = seen_q;
         if (rise) begin
            per_cnt_d = CNT_W'(1);
            seen_d    = 1'b1;
            if (seen_q) begin
               period_d = per_cnt_q;
               pvalid_d = 1'b1;
            end
         end
         if (win_end) seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_q <= '0;
         period_q  <= '0;
         seen_q    <= 1'b0;
         pvalid_q  <= 1'b0;
      end else begin
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
         seen_q    <= seen_d;
         pvalid_q  <= pvalid_d;
      end
   end

   assign mtr.period_o       = period_q;
   assign mtr.period_valid_o = pvalid_q;
`endif

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
Receive-side counterpart of the team's clock dividers. Measures an incoming slow clock or divided clock (sig_in, asynchronous to clk) by counting its rising edges over a fixed gate window of clk cycles. Publishes the count once per window with a one-cycle valid strobe. Used on-chip to check divider outputs and external reference clocks.

Parameters:
GATE_CYCLES, 1000, gate window length in clk cycles (>= 4)
CNT_W, 16, width of edge count output
SYNC_STAGES, 2, synchronizer flop depth for sig_in (>= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  measurement enable; low = idle
sig_in  input  1  signal under measurement, asynchronous to clk
count_o  output  CNT_W  rising-edge count of last completed window
valid_o  output  1  one-cycle pulse when count_o updates
ovf_o  output  1  last completed window saturated
busy_o  output  1  high while a window is in progress

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: all outputs 0, FSM in IDLE, synchronizer and counters cleared.
- sig_in passes SYNC_STAGES flops, then an edge register; rise = sync & ~prev. Edge is counted 3 cycles after the sig_in transition at default depth.
- FSM states: IDLE, ARM, GATE.
- IDLE: busy_o=0, counters held at 0. ena=1 moves to ARM.
- ARM: exactly 1 cycle. Loads prev with the current synced value, so a high level already present is not counted as an edge. Clears gate_cnt and edge_cnt. Moves to GATE.
- GATE: busy_o=1. gate_cnt increments each cycle. edge_cnt increments on rise and saturates at 2^CNT_W-1; saturation sets an internal ovf flag.
- End of window (gate_cnt == GATE_CYCLES-1):
  - count_o <= edge_cnt, including a rise occurring in this same cycle.
  - ovf_o <= ovf flag.
  - valid_o=1 next cycle.
  - Counters clear and the next window starts on the following cycle, back to back with no ARM and no dead cycle.
  - A rise on the first cycle of the new window counts in the new window.
- ena falls mid-window: next state IDLE. The partial window is discarded, no valid_o, and count_o/ovf_o keep their last values.
- ena re-asserted: passes through ARM again.
- valid_o is never asserted for two consecutive cycles. It is not back-pressured, so a consumer must sample it.
- rst_n asserted mid-window: immediate return to reset state; count_o=0.

Optional Feature:
FREQ_METER_PERIOD_EN
- Defined: adds outputs period_o [CNT_W] and period_valid_o.
  - In GATE, a period counter measures clk cycles between consecutive rises.
  - On each rise after the first in a window, period_o latches the count and period_valid_o pulses 1 cycle.
  - The counter saturates at 2^CNT_W-1.
  - The counter restarts on ARM; no period is reported across an ena drop.
- Undefined: these ports and their logic are absent; all other behaviour is unchanged.

Decomposition:
- Package clk_freq_meter_pkg:
  - state enum (IDLE, ARM, GATE)
  - GATE_W localparam function, ceil log2 of GATE_CYCLES
  - saturation max constant helper
- One sub-module, sync_rise_det: SYNC_STAGES synchronizer, prev register, rise output, and a load_prev input driven by ARM. Reusable for other async inputs.

Test Plan:
- GATE_CYCLES=100; sig_in toggles every 5 clk (period 10). Expected: first valid_o at cycle 102 after ena rise (1 ARM cycle + 100 GATE cycles + 1), count_o=10, ovf_o=0. Continuous windows every 100 cycles, each reporting 10 (±1 on the first window only, depending on phase).
- sig_in held high before ena rises, no further edges: count_o=0 (ARM suppresses the spurious edge).
- CNT_W=4, GATE_CYCLES=100, sig_in period 4 (25 edges): count_o=15, ovf_o=1. Next window with sig_in stopped: count_o=0, ovf_o=0.
- ena dropped at gate cycle 50: no valid_o, count_o holds the previous value, busy_o falls 1 cycle later. Re-enable: a fresh full window is reported.
- rst_n pulsed low asynchronously mid-window (not clock-aligned): all outputs 0 immediately. Measurement resumes correctly after release.
- FREQ_METER_PERIOD_EN, sig_in period 10: period_o=10, with period_valid_o pulsing every 10 cycles starting at the 2nd rise.
